// File: rtl/serial_add_ctrl.sv
// Bit-serial unsigned adder with an IDLE/RUN/DONE controller.
// Operands are latched on an accepted start, then one bit per clock is
// pushed LSB-first through a single full-adder slice. The complete result
// is published on sum/cout when the last bit is processed and held until
// the next completion.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic fa_a, fa_b, ha1_s, ha1_c, ha2_c, fa_s, fa_co;

    // Shared full-adder slice built from two half adders and an OR.
    always_comb begin
        fa_a  = a_sh_q[0];
        fa_b  = b_sh_q[0];
        ha1_s = fa_a ^ fa_b;
        ha1_c = fa_a & fa_b;
        fa_s  = ha1_s ^ carry_q;
        ha2_c = ha1_s & carry_q;
        fa_co = ha1_c | ha2_c;
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Result fills from the MSB end so bit 0 lands at the LSB
                // after WIDTH shifts.
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_co;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_DONE);
        done_d = (state_d == S_DONE);
    end

    // Single state register bank with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8): stimulus pushes the
// expected {cout,sum} and completion cycle; a monitor pops on every done.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int         at;
        logic [W:0] val;
    } exp_t;
    exp_t sb[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Edge counter used to time-stamp expected completions.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.at);
                check("result", {cout, sum}, e.val);
            end
        end
    end

    // Issue one addition at the current negedge and track busy through it.
    // scramble: operands go to 0 right after acceptance.
    // poke: a second start is raised 3 cycles after acceptance.
    task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W:0] exp, input bit scramble, input bit poke);
        exp_t e;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        e.at = cyc + 1 + W;
        e.val = exp;
        sb.push_back(e);
        for (int i = 0; i <= W; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (scramble && i == 0) begin a = '0; b = '0; end
            if (poke && i == 2) begin a = 8'h01; b = 8'h01; start = 1'b1; end
            check("busy_run", busy, 1'b1);
        end
        @(negedge clk);
        check("busy_idle", busy, 1'b0);
        check("done_idle", done, 1'b0);
    endtask

    initial begin
        // Reset state.
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", sum, '0);
        check("rst_cout", cout, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_add(8'h00, 8'h00, 9'h000, 0, 0);
        do_add(8'hFF, 8'h01, 9'h100, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_sum", sum, 8'h00);
            check("hold_cout", cout, 1'b1);
        end
        do_add(8'hA5, 8'h5A, 9'h0FF, 1, 0);
        do_add(8'h10, 8'h20, 9'h030, 0, 1);
        do_add(8'hFF, 8'hFF, 9'h1FE, 0, 0);
        do_add(8'h80, 8'h80, 9'h100, 0, 0);
        do_add(8'h7F, 8'h01, 9'h080, 0, 0);
        do_add(8'h55, 8'hAA, 9'h0FF, 0, 0);
        do_add(8'h10, 8'h20, 9'h030, 0, 0);

        // Abort mid-RUN with an asynchronous reset between edges.
        begin
            exp_t e;
            @(negedge clk);
            a = 8'h77; b = 8'h11; start = 1'b1;
            e.at = cyc + 1 + W;
            e.val = 9'h088;
            sb.push_back(e);
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            #2;
            rst_n = 1'b0;
            void'(sb.pop_back());
            #1;
            check("abort_busy", busy, 1'b0);
            check("abort_done", done, 1'b0);
            check("abort_sum", sum, '0);
            check("abort_cout", cout, 1'b0);
            repeat (12) @(negedge clk);
            rst_n = 1'b1;
        end
        do_add(8'h33, 8'h44, 9'h077, 0, 0);

        // Back-to-back with start held high: one result every W+2 cycles.
        @(negedge clk);
        for (int n = 0; n < 1000; n++) begin
            exp_t e;
            logic [W-1:0] x, y;
            x = W'($urandom);
            y = W'($urandom);
            a = x; b = y; start = 1'b1;
            e.at = cyc + 1 + W;
            e.val = {1'b0, x} + {1'b0, y};
            sb.push_back(e);
            @(negedge clk);
            a = W'($urandom);
            b = W'($urandom);
            repeat (W + 1) @(negedge clk);
        end
        start = 1'b0;

        repeat (15) @(negedge clk);
        check("queue_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
